// File: rtl/mem_arbiter_pkg.sv
// Package for mem_arbiter: FSM state and owner enums and the default widths.
// Widths are defaults only. Modules derive their byte-enable width from their own DATA_W.
package arb_pkg;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    // Byte enables used for a fetch at the default data width.
    localparam logic [ARB_DATA_W/8-1:0] BE_ALL = '1;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus of mem_arbiter.
// master : the arbiter. Drives req/we/addr/wdata/be and receives rdata/ack.
// slave  : the memory model or controller.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_be;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_arbiter_streak_ctr.sv
// arb_streak_ctr: saturating count of data grants made while a fetch is waiting.
// Ports:
//   clk, clr_n : clock and asynchronous active-low reset
//   inc        : count one data grant; the count holds once it reaches MAX_D_STREAK
//   clr        : clear the count; takes priority over inc
//   sat        : the count equals MAX_D_STREAK
module arb_streak_ctr #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int CW = $clog2(MAX_D_STREAK + 1);

    logic [CW-1:0] cnt;

    assign sat = (cnt == CW'(MAX_D_STREAK));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)          cnt <= '0;
        else if (clr)        cnt <= '0;
        else if (inc && !sat) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch port (IF) and
// the load/store port (MEM).
//
// Behaviour:
//   - Data requests normally win over fetch requests. After MAX_D_STREAK data
//     grants made while a fetch was waiting, the fetch is granted next.
//   - Each access passes through IDLE, then BUSY, then RESP. The owner's ready
//     output pulses for one cycle in RESP.
//
// Ports:
//   clk, clr_n                       : clock and asynchronous active-low reset
//   if_req/if_addr                   : fetch request input
//   if_rdata/if_ready                : fetch response output
//   d_req/d_we/d_addr/d_wdata/d_be   : load/store request input
//   d_rdata/d_ready                  : load/store response output
//   mem                              : memory bus (master side)
//   stall_if, stall_mem              : stall requests to the hazard unit
//   bus_err                          : present only when MEM_ARBITER_TIMEOUT_EN is
//                                      defined; high in RESP after a watchdog timeout
//
// Optional feature, macro MEM_ARBITER_TIMEOUT_EN:
//   When the macro is defined, a BUSY state that waits TIMEOUT_CYCLES cycles
//   without mem_ack ends the access with rdata = 0 and bus_err = 1.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W         = ARB_ADDR_W,
    parameter int DATA_W         = ARB_DATA_W,
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    mem_arbiter_if.master       mem,
    output logic                stall_if,
    output logic                stall_mem
`ifdef MEM_ARBITER_TIMEOUT_EN
    ,
    output logic                bus_err
`endif
);
    localparam int BE_W = DATA_W / 8;

    arb_state_t state_q, state_d;
    owner_t     owner;
    logic       grant_d, grant_i, done, busy, streak_sat;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            timeout;
`endif

    assign busy  = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign owner = (state_q == BUSY_D) ? OWN_D : OWN_I;

    // The ready outputs are registered, so these stalls drop in the RESP cycle.
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;

    arb_streak_ctr #(.MAX_D_STREAK(MAX_D_STREAK)) u_streak (
        .clk   (clk),
        .clr_n (clr_n),
        .inc   (grant_d & if_req),
        .clr   (grant_i | (grant_d & ~if_req)),
        .sat   (streak_sat)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Grants are made only from IDLE. A requester that is still holding its
    // request while it sees ready therefore cannot be issued a second time.
    always_comb begin
        state_d = state_q;
        grant_d = 1'b0;
        grant_i = 1'b0;
        done    = 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
        timeout = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (d_req && !(if_req && streak_sat)) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                end else if (if_req) begin
                    grant_i = 1'b1;
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem.mem_ack) begin
                    done    = 1'b1;
                    state_d = RESP;
                end
`ifdef MEM_ARBITER_TIMEOUT_EN
                else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_be    <= '0;
            if_rdata      <= '0;
            d_rdata       <= '0;
            if_ready      <= 1'b0;
            d_ready       <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            if (grant_d || grant_i) begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= grant_d & d_we;
                mem.mem_addr  <= grant_d ? d_addr : if_addr;
                mem.mem_wdata <= grant_d ? d_wdata : '0;
                mem.mem_be    <= grant_d ? d_be : {BE_W{1'b1}};
            end
            if (done) begin
                mem.mem_req <= 1'b0;
                if (owner == OWN_I) begin
                    if_ready <= 1'b1;
                    if_rdata <= mem.mem_rdata;
                end else begin
                    d_ready <= 1'b1;
                    // A store leaves the last load data unchanged.
                    if (!mem.mem_we) d_rdata <= mem.mem_rdata;
                end
            end
`ifdef MEM_ARBITER_TIMEOUT_EN
            if (timeout) begin
                mem.mem_req <= 1'b0;
                if (owner == OWN_I) begin
                    if_ready <= 1'b1;
                    if_rdata <= '0;
                end else begin
                    d_ready <= 1'b1;
                    d_rdata <= '0;
                end
            end
`endif
        end
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    // wd_cnt counts BUSY cycles and restarts from 0 at each grant.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wd_cnt  <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= timeout;
            if (grant_d || grant_i) wd_cnt <= '0;
            else if (busy)          wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    logic unused_busy;
    assign unused_busy = busy;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter.
// When MEM_ARBITER_TIMEOUT_EN is defined, the bench also exercises the watchdog
// with TIMEOUT_CYCLES = 8.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        clr_n;
    logic        if_req, if_ready, d_req, d_we, d_ready, stall_if, stall_mem;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
`ifdef MEM_ARBITER_TIMEOUT_EN
    logic        bus_err;
`endif
    int total = 0;
    int bad   = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .clr_n(clr_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem(bus.master),
        .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef MEM_ARBITER_TIMEOUT_EN
        , .bus_err(bus_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clr_n = 1'b0; if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        tick; tick;
        total++;
        if ({bus.mem_req, bus.mem_we, if_ready, d_ready} !== 4'b0 || bus.mem_addr !== '0 ||
            bus.mem_wdata !== '0 || bus.mem_be !== 4'h0 || if_rdata !== '0 || d_rdata !== '0) begin
            bad++;
            $display("FAIL reset_values: req=%b addr=%h be=%h ifr=%h dr=%h, required all 0",
                     bus.mem_req, bus.mem_addr, bus.mem_be, if_rdata, d_rdata);
        end
        // A stray ack arriving right after reset must be ignored.
        clr_n = 1'b1;
        tick;
        total++;
        if (if_ready !== 1'b0 || d_ready !== 1'b0 || bus.mem_req !== 1'b0) begin
            bad++;
            $display("FAIL stray_ack: if_ready=%b d_ready=%b mem_req=%b, required 0 0 0",
                     if_ready, d_ready, bus.mem_req);
        end
        bus.mem_ack = 1'b0;
        tick;
    endtask

    task automatic test_fetch;
        if_req = 1; if_addr = 32'h100;
        tick;
        total++;
        if (bus.mem_req !== 1 || bus.mem_we !== 0 || bus.mem_be !== 4'hF ||
            bus.mem_addr !== 32'h100 || stall_if !== 1) begin
            bad++;
            $display("FAIL fetch_issue: req=%b we=%b be=%h addr=%h stall_if=%b, required 1 0 f 100 1",
                     bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, stall_if);
        end
        bus.mem_ack = 1; bus.mem_rdata = 32'h0050_0093;
        tick;
        bus.mem_ack = 0;
        total++;
        if (if_ready !== 1 || if_rdata !== 32'h0050_0093 || bus.mem_req !== 0 || stall_if !== 0) begin
            bad++;
            $display("FAIL fetch_resp: ready=%b rdata=%h req=%b stall_if=%b, required 1 00500093 0 0",
                     if_ready, if_rdata, bus.mem_req, stall_if);
        end
        // if_req is still high in RESP. No grant may come out of RESP.
        tick;
        total++;
        if (bus.mem_req !== 0 || if_ready !== 0) begin
            bad++;
            $display("FAIL fetch_no_reissue: req=%b ready=%b, required 0 0", bus.mem_req, if_ready);
        end
        if_req = 0;
        tick;
    endtask

    task automatic test_slow_memory;
        int unstable = 0;
        d_req = 1; d_we = 0; d_addr = 32'h4000; d_wdata = 32'h55AA_55AA; d_be = 4'hF;
        tick;
        for (int i = 0; i < 10; i++) begin
            if (bus.mem_req !== 1 || bus.mem_addr !== 32'h4000 || bus.mem_wdata !== 32'h55AA_55AA ||
                stall_mem !== 1 || d_ready !== 0) unstable++;
            if (i == 9) begin bus.mem_ack = 1; bus.mem_rdata = 32'h1122_3344; end
            else tick;
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL slow_hold: %0d unstable BUSY cycles, required 0", unstable);
        end
        tick;
        bus.mem_ack = 0;
        total++;
        if (d_ready !== 1 || d_rdata !== 32'h1122_3344 || stall_mem !== 0) begin
            bad++;
            $display("FAIL slow_resp: ready=%b rdata=%h stall_mem=%b, required 1 11223344 0",
                     d_ready, d_rdata, stall_mem);
        end
        d_req = 0;
        tick;
    endtask

    task automatic test_simultaneous;
        if_req = 1; if_addr = 32'h104;
        d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hCAFE_BABE; d_be = 4'b1100;
        tick;
        total++;
        if (bus.mem_req !== 1 || bus.mem_we !== 1 || bus.mem_be !== 4'b1100 ||
            bus.mem_addr !== 32'h2004 || bus.mem_wdata !== 32'hCAFE_BABE) begin
            bad++;
            $display("FAIL simul_data_first: we=%b be=%b addr=%h wdata=%h, required 1 1100 2004 cafebabe",
                     bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
        end
        bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD_BEEF;
        tick;
        bus.mem_ack = 0;
        total++;
        if (d_ready !== 1 || d_rdata !== 32'h1122_3344 || if_ready !== 0) begin
            bad++;
            $display("FAIL simul_store_resp: d_ready=%b d_rdata=%h if_ready=%b, required 1 11223344 0",
                     d_ready, d_rdata, if_ready);
        end
        d_req = 0;
        tick; // IDLE: the pending fetch is granted here
        tick;
        total++;
        if (bus.mem_req !== 1 || bus.mem_we !== 0 || bus.mem_be !== 4'hF || bus.mem_addr !== 32'h104) begin
            bad++;
            $display("FAIL simul_fetch_after: req=%b we=%b be=%h addr=%h, required 1 0 f 104",
                     bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr);
        end
        bus.mem_ack = 1; bus.mem_rdata = 32'h0000_0013;
        tick;
        bus.mem_ack = 0;
        total++;
        if (if_ready !== 1 || if_rdata !== 32'h13) begin
            bad++;
            $display("FAIL simul_fetch_resp: ready=%b rdata=%h, required 1 00000013", if_ready, if_rdata);
        end
        if_req = 0;
        tick;
    endtask

    task automatic test_starvation;
        logic [31:0] got [6];
        logic [31:0] exp [6];
        int n = 0;
        exp = '{32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h200, 32'h3000};
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 0; d_addr = 32'h3000; d_be = 4'hF;
        bus.mem_rdata = 32'h0BAD_0001;
        for (int c = 0; c < 40 && n < 6; c++) begin
            tick;
            if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b0) begin
                got[n] = bus.mem_addr;
                n++;
                bus.mem_ack = 1;
            end else begin
                bus.mem_ack = 0;
            end
        end
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL starve_grants: %0d grants seen, required 6", n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++;
                $display("FAIL starve_order[%0d]: addr=%h, required %h", i, got[i], exp[i]);
            end
        end
        tick;
        bus.mem_ack = 0; if_req = 0; d_req = 0;
        tick;
    endtask

`ifdef MEM_ARBITER_TIMEOUT_EN
    task automatic test_timeout;
        int early = 0;
        if_req = 1; if_addr = 32'h600;
        tick;
        for (int i = 0; i < 8; i++) begin
            if (bus.mem_req !== 1 || if_ready !== 0 || bus_err !== 0) early++;
            if (i < 7) tick;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL timeout_busy: %0d bad BUSY cycles, required 0", early);
        end
        tick;
        total++;
        if (bus_err !== 1 || if_ready !== 1 || if_rdata !== '0 || bus.mem_req !== 0) begin
            bad++;
            $display("FAIL timeout_resp: bus_err=%b ready=%b rdata=%h req=%b, required 1 1 0 0",
                     bus_err, if_ready, if_rdata, bus.mem_req);
        end
        if_req = 0;
        tick;
        total++;
        if (bus_err !== 0 || if_ready !== 0) begin
            bad++;
            $display("FAIL timeout_pulse: bus_err=%b ready=%b, required 0 0", bus_err, if_ready);
        end
    endtask
`endif

    task automatic test_reset_busy;
        d_req = 1; d_we = 0; d_addr = 32'h5000; d_be = 4'hF;
        tick;
        total++;
        if (bus.mem_req !== 1 || bus.mem_addr !== 32'h5000) begin
            bad++;
            $display("FAIL rbusy_issue: req=%b addr=%h, required 1 5000", bus.mem_req, bus.mem_addr);
        end
        clr_n = 0;
        #1;
        total++;
        if (bus.mem_req !== 0 || bus.mem_addr !== '0) begin
            bad++;
            $display("FAIL rbusy_async: req=%b addr=%h, required 0 0", bus.mem_req, bus.mem_addr);
        end
        tick;
        clr_n = 1; d_req = 0; bus.mem_ack = 1; bus.mem_rdata = 32'h7777_7777;
        tick;
        bus.mem_ack = 0;
        total++;
        if (d_ready !== 0 || bus.mem_req !== 0 || d_rdata !== '0) begin
            bad++;
            $display("FAIL rbusy_ack_ignored: d_ready=%b req=%b d_rdata=%h, required 0 0 0",
                     d_ready, bus.mem_req, d_rdata);
        end
        tick;
        total++;
        if (d_ready !== 0 || bus.mem_req !== 0) begin
            bad++;
            $display("FAIL rbusy_idle: d_ready=%b req=%b, required 0 0", d_ready, bus.mem_req);
        end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_slow_memory;
        test_simultaneous;
        test_starvation;
`ifdef MEM_ARBITER_TIMEOUT_EN
        test_timeout;
`endif
        test_reset_busy;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
